// File: rtl/pet_pkg.sv
// Shared definitions for the pet needs controller: state encoding, counter width
// and a lowest-set-bit helper used to pick which need gets served.
package pet_pkg;

    localparam int unsigned CNT_W = 12;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_NEEDY   = 2'd1;
    localparam logic [1:0] ST_ENGAGED = 2'd2;
    localparam logic [1:0] ST_CARING  = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = ST_IDLE,
        StNeedy   = ST_NEEDY,
        StEngaged = ST_ENGAGED,
        StCaring  = ST_CARING
    } state_e;

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pet_sec_prescaler.sv
// One-second strobe generator: counts 0..CLK_HZ-1, sec_tick is high for the
// single cycle in which the count has just wrapped back to 0.
module pet_sec_prescaler #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic reset,
    output logic sec_tick
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick_q;
    logic          wrap;

    always_comb begin
        wrap  = (cnt_q == PW'(CLK_HZ - 1));
        cnt_d = wrap ? '0 : cnt_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= wrap;
        end
    end

    assign sec_tick = tick_q;

endmodule

// File: rtl/pet_needs_ctrl.sv
// Virtual-pet needs controller: per-need elapsed timers, pending flags and the
// IDLE/NEEDY/ENGAGED/CARING episode FSM. Define PET_PROX_GATE_EN to gate engage on proximity.
module pet_needs_ctrl
    import pet_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned N_NEEDS     = 3,
    parameter int unsigned TIMEOUT_S   = 60,
    parameter int unsigned ENGAGE_TO_S = 10,
    parameter int unsigned NEAR_CM     = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [15:0]        dist_cm,
    input  logic               dist_valid,
    input  logic               engage,
    input  logic [N_NEEDS-1:0] act,
    input  logic               confirm,
    output logic [1:0]         state,
    output logic [N_NEEDS-1:0] need_flags,
    output logic [2:0]         cared_need,
    output logic [CNT_W-1:0]   worst_elapsed,
    output logic               sec_tick
);

    logic               tick;
    logic               engage_ok;
    logic               served;
    logic               any_flag;
    logic [N_NEEDS-1:0] clear;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   el_q [N_NEEDS];
    logic [CNT_W-1:0]   el_d [N_NEEDS];
    logic [N_NEEDS-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]   eng_q, eng_d;
    logic [2:0]         cared_q, cared_d;
    logic [CNT_W-1:0]   worst_q, worst_d;

    pet_sec_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .sec_tick(tick)
    );

`ifdef PET_PROX_GATE_EN
    logic near;
    assign near      = enable && dist_valid && (dist_cm <= 16'(NEAR_CM));
    assign engage_ok = engage && near;
`else
    logic unused_prox;
    assign unused_prox = ^{enable, dist_valid, dist_cm};
    assign engage_ok   = engage;
`endif

    assign any_flag = |flags_q;

    // Only the lowest-indexed act bit is honoured, and only while ENGAGED.
    always_comb begin
        served  = (state_q == StEngaged) && (|act);
        clear   = served ? (act & (~act + N_NEEDS'(1))) : '0;
        cared_d = served ? lowest_set(8'(act)) : cared_q;
    end

    always_comb begin
        for (int i = 0; i < N_NEEDS; i++) begin
            el_d[i]    = el_q[i];
            flags_d[i] = flags_q[i];
            if (clear[i]) begin
                el_d[i]    = '0;
                flags_d[i] = 1'b0;
            end else begin
                if (tick && (el_q[i] < CNT_W'(TIMEOUT_S))) el_d[i] = el_q[i] + CNT_W'(1);
                if (el_d[i] == CNT_W'(TIMEOUT_S)) flags_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        worst_d = '0;
        for (int i = 0; i < N_NEEDS; i++) begin
            if (el_q[i] > worst_d) worst_d = el_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        eng_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (engage_ok)     state_d = StEngaged;
                else if (any_flag) state_d = StNeedy;
            end
            StNeedy: begin
                if (engage_ok) state_d = StEngaged;
            end
            StEngaged: begin
                if (served) begin
                    state_d = StCaring;
                end else if (tick) begin
                    if ((32'(eng_q) + 32'd1) >= ENGAGE_TO_S) state_d = any_flag ? StNeedy : StIdle;
                    else                                     eng_d   = eng_q + CNT_W'(1);
                end else begin
                    eng_d = eng_q;
                end
            end
            StCaring: begin
                if (confirm) state_d = any_flag ? StNeedy : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            flags_q <= '0;
            eng_q   <= '0;
            cared_q <= '0;
            worst_q <= '0;
            for (int i = 0; i < N_NEEDS; i++) el_q[i] <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            eng_q   <= eng_d;
            cared_q <= cared_d;
            worst_q <= worst_d;
            for (int i = 0; i < N_NEEDS; i++) el_q[i] <= el_d[i];
        end
    end

    assign state         = state_q;
    assign need_flags    = flags_q;
    assign cared_need    = cared_q;
    assign worst_elapsed = worst_q;
    assign sec_tick      = tick;

endmodule

// File: tb/tb_pet_needs_ctrl.sv
// Self-checking bench for pet_needs_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model of the need/episode rules.
module tb_pet_needs_ctrl;

    localparam int CLK = 4;
    localparam int N   = 3;
    localparam int TO  = 3;
    localparam int ETO = 2;
    localparam int NR  = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [15:0]  dist_cm;
    logic         dist_valid;
    logic         engage;
    logic [N-1:0] act;
    logic         confirm;
    logic [1:0]   state;
    logic [N-1:0] need_flags;
    logic [2:0]   cared_need;
    logic [11:0]  worst_elapsed;
    logic         sec_tick;

    pet_needs_ctrl #(
        .CLK_HZ     (CLK),
        .N_NEEDS    (N),
        .TIMEOUT_S  (TO),
        .ENGAGE_TO_S(ETO),
        .NEAR_CM    (NR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .dist_cm      (dist_cm),
        .dist_valid   (dist_valid),
        .engage       (engage),
        .act          (act),
        .confirm      (confirm),
        .state        (state),
        .need_flags   (need_flags),
        .cared_need   (cared_need),
        .worst_elapsed(worst_elapsed),
        .sec_tick     (sec_tick)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: 0 idle, 1 needy, 2 engaged, 3 caring.
    int     m_cnt;
    bit     m_tick;
    int     m_el [N];
    bit [N-1:0] m_fl;
    int     m_state;
    int     m_eng;
    int     m_cared;
    int     m_worst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int n_el [N];
        bit [N-1:0] n_fl;
        int srv;
        int secs_engaged;
        bit eng_ok;
        bit pending;
        if (reset) begin
            m_cnt = 0; m_tick = 0; m_fl = '0; m_state = 0;
            m_eng = 0; m_cared = 0; m_worst = 0;
            for (int i = 0; i < N; i++) m_el[i] = 0;
            return;
        end
`ifdef PET_PROX_GATE_EN
        eng_ok = engage && enable && dist_valid && (int'(dist_cm) <= NR);
`else
        eng_ok = engage;
`endif
        pending = (m_fl != 0);
        srv = -1;
        if (m_state == 2) begin
            for (int i = 0; i < N; i++) if (act[i] && srv < 0) srv = i;
        end
        m_worst = 0;
        for (int i = 0; i < N; i++) if (m_el[i] > m_worst) m_worst = m_el[i];
        for (int i = 0; i < N; i++) begin
            if (i == srv) begin
                n_el[i] = 0;
                n_fl[i] = 0;
            end else begin
                n_el[i] = (m_tick && m_el[i] < TO) ? m_el[i] + 1 : m_el[i];
                n_fl[i] = m_fl[i] || (n_el[i] == TO);
            end
        end
        secs_engaged = m_eng + (m_tick ? 1 : 0);
        case (m_state)
            0: begin
                if (eng_ok) begin m_state = 2; m_eng = 0; end
                else if (pending) m_state = 1;
            end
            1: if (eng_ok) begin m_state = 2; m_eng = 0; end
            2: begin
                if (srv >= 0) begin
                    m_state = 3; m_cared = srv; m_eng = 0;
                end else if (secs_engaged >= ETO) begin
                    m_state = pending ? 1 : 0; m_eng = 0;
                end else begin
                    m_eng = secs_engaged;
                end
            end
            default: if (confirm) m_state = pending ? 1 : 0;
        endcase
        for (int i = 0; i < N; i++) m_el[i] = n_el[i];
        m_fl   = n_fl;
        m_tick = (m_cnt == CLK - 1);
        m_cnt  = m_tick ? 0 : m_cnt + 1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("state", 32'(state), 32'(m_state));
        check("need_flags", 32'(need_flags), 32'(m_fl));
        check("cared_need", 32'(cared_need), 32'(m_cared));
        check("worst_elapsed", 32'(worst_elapsed), 32'(m_worst));
        check("sec_tick", 32'(sec_tick), 32'(m_tick));
    endtask

    task automatic pulse(input bit e, input logic [N-1:0] a, input bit c);
        engage = e; act = a; confirm = c;
        step();
        engage = 0; act = '0; confirm = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1; enable = 1; dist_valid = 1; dist_cm = 16'd5;
        engage = 0; act = '0; confirm = 0;
        m_cnt = 0; m_tick = 0; m_fl = '0; m_state = 0;
        m_eng = 0; m_cared = 0; m_worst = 0;
        for (int i = 0; i < N; i++) m_el[i] = 0;

        // Reset state
        idle(2);
        check("rst_state", 32'(state), 32'd0);
        check("rst_flags", 32'(need_flags), 32'd0);
        reset = 0;

        // Untended pet: all needs time out
        idle(16);
        check("to_flags", 32'(need_flags), 32'b111);
        check("to_state", 32'(state), 32'd1);
        check("to_worst", 32'(worst_elapsed), 32'd3);

        // Engage, serve two needs at once (lowest wins), confirm
        pulse(1, '0, 0);
        check("eng_state", 32'(state), 32'd2);
        pulse(0, 3'b110, 0);
        check("care_state", 32'(state), 32'd3);
        check("care_flags", 32'(need_flags), 32'b101);
        check("care_idx", 32'(cared_need), 32'd1);
        pulse(1, 3'b001, 0);
        check("caring_ignore", 32'(state), 32'd3);
        pulse(0, '0, 1);
        check("confirm_state", 32'(state), 32'd1);

        // Proximity gating
        dist_cm = 16'd6;
        pulse(1, '0, 0);
`ifdef PET_PROX_GATE_EN
        check("far_engage", 32'(state), 32'd1);
        dist_cm = 16'd5; enable = 0;
        pulse(1, '0, 0);
        check("disabled_engage", 32'(state), 32'd1);
        enable = 1;
        pulse(1, '0, 0);
`else
        check("ungated_engage", 32'(state), 32'd2);
        dist_cm = 16'd5;
`endif
        // Engagement timeout with pending flags
        idle(10);
        check("eto_needy", 32'(state), 32'd1);

        // Engagement timeout with nothing pending
        reset = 1; step(); reset = 0;
        pulse(1, '0, 0);
        idle(10);
        check("eto_idle", 32'(state), 32'd0);

        // Care action coinciding with a second tick
        pulse(1, '0, 0);
        for (int i = 0; i < 8 && !m_tick; i++) step();
        check("tick_aligned", 32'(sec_tick), 32'd1);
        pulse(0, 3'b001, 0);
        idle(14);

        // Reset in the middle of a care episode
        pulse(1, '0, 0);
        pulse(0, 3'b100, 0);
        check("pre_rst_caring", 32'(state), 32'd3);
        reset = 1; step(); reset = 0;
        check("rst_care_state", 32'(state), 32'd0);
        check("rst_care_flags", 32'(need_flags), 32'd0);
        check("rst_care_idx", 32'(cared_need), 32'd0);
        check("rst_care_worst", 32'(worst_elapsed), 32'd0);
        check("rst_care_tick", 32'(sec_tick), 32'd0);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            enable     = ($urandom_range(0, 3) != 0);
            dist_valid = ($urandom_range(0, 3) != 0);
            dist_cm    = 16'($urandom_range(0, 10));
            engage     = ($urandom_range(0, 7) == 0);
            act        = ($urandom_range(0, 3) == 0) ? N'($urandom_range(1, 7)) : '0;
            confirm    = ($urandom_range(0, 4) == 0);
            reset      = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 0; engage = 0; act = '0; confirm = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
